// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU feeding write-back into the 8x16 register file.
// Single-cycle logic/arith ops, 16-step shift-add multiply, and an optional
// 16-step restoring divider enabled by the ALU_DIV_EN macro. Without it,
// opcode 10 is reported as illegal.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// EXEC   | one multiply/divide step per cycle, counter counts down to 0
// DONE   | done (and WE_out unless error) asserted for this single cycle
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int ITER  = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err,
  output logic             WE_out,
  output logic [AW-1:0]    W_out
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [AW-1:0]    dest_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_err, sc_multi;
  logic [WIDTH:0]   add_s, sub_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign busy  = (state != S_IDLE);
  assign add_s = {1'b0, A} + {1'b0, B};
  assign sub_d = {1'b0, A} - {1'b0, B};

  // Decode of the single-cycle ops straight from the input operands
  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_err   = 1'b0;
    sc_multi = 1'b0;
    case (op)
      4'd0: begin
        sc_res = add_s[WIDTH-1:0];
        sc_c   = add_s[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        sc_res = sub_d[WIDTH-1:0];
        sc_c   = sub_d[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_d[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: sc_res = A & B;
      4'd3: sc_res = A | B;
      4'd4: sc_res = A ^ B;
      4'd5: sc_res = ~A;
      4'd6: sc_res = A << B[3:0];
      4'd7: sc_res = A >> B[3:0];
      4'd8: sc_res = WIDTH'($signed(A) >>> B[3:0]);
      OP_MUL: sc_multi = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV: sc_multi = 1'b1;
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // Shift-add multiply step: {acc_hi,acc_lo} starts as {0,B}, shifts right
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0] div_sh, div_diff;
  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts
  // dividend bits out and quotient bits in
  always_comb begin
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      div_hi_n = div_diff[WIDTH-1:0];
      div_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_n = div_sh[WIDTH-1:0];
      div_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end
`else
  assign div_hi_n = '0;
  assign div_lo_n = '0;
`endif

  assign step_hi = (op_q == OP_DIV) ? div_hi_n : mul_hi_n;
  assign step_lo = (op_q == OP_DIV) ? div_lo_n : mul_lo_n;

  // Sequencer with registered results, flags and write-back request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_err  <= 1'b0;
      WE_out    <= 1'b0;
      W_out     <= '0;
    end else begin
      done   <= 1'b0;
      WE_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            op_q   <= op;
            dest_q <= dest;
            if (sc_multi) begin
              cnt    <= CW'(ITER - 1);
              acc_hi <= '0;
              acc_lo <= (op == OP_DIV) ? A : B;
              state  <= S_EXEC;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              WE_out    <= !sc_err;
              result    <= sc_res;
              result_hi <= '0;
              flag_z    <= (sc_res == '0);
              flag_c    <= sc_c;
              flag_v    <= sc_v;
              flag_err  <= sc_err;
              W_out     <= dest;
            end
          end
        end
        S_EXEC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == '0) begin
            state  <= S_DONE;
            done   <= 1'b1;
            W_out  <= dest_q;
            flag_v <= 1'b0;
            if (op_q == OP_DIV && b_q == '0) begin
              result    <= '1;
              result_hi <= a_q;
              flag_z    <= 1'b0;
              flag_c    <= 1'b0;
              flag_err  <= 1'b1;
            end else begin
              result    <= step_lo;
              result_hi <= step_hi;
              flag_z    <= (step_lo == '0);
              flag_c    <= (op_q == OP_MUL) && (step_hi != '0);
              flag_err  <= 1'b0;
              WE_out    <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle ALU directly downstream of the 8x16 register file.
- Consumes the RF's two registered read-data words as operands A and B, and executes one operation per accepted start.
- Returns a registered result, flags and a write-back request (dest register + write enable) that feed the RF's W1/WE/Din port.
- Single-cycle logic/arith ops; iterative shift-add multiply and restoring divide.

Parameters:
- WIDTH, 16, operand/result width; must match RF data width.
- AW, 3, destination register address width (8 registers).
- ITER, 16, iteration count for MUL/DIV; must equal WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  4  opcode, sampled with start.
- A  input  WIDTH  operand 1, from RF Dout_1.
- B  input  WIDTH  operand 2, from RF Dout_2.
- dest  input  AW  write-back register number, sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result/flags valid in that cycle.
- result  output  WIDTH  primary result (MUL low half, DIV quotient).
- result_hi  output  WIDTH  MUL high half, DIV remainder, else 0.
- flag_z  output  1  result==0.
- flag_c  output  1  carry/borrow, or MUL high half nonzero.
- flag_v  output  1  signed overflow (ADD/SUB only).
- flag_err  output  1  illegal opcode or divide-by-zero.
- WE_out  output  1  write-back enable to RF, pulses with done.
- W_out  output  AW  write-back register number (latched dest).

Behaviour:
- Reset (async, RST_N=0): state=IDLE, counter=0, all outputs 0, operand/op/dest latches 0. Reset mid-MUL/DIV aborts with no done and no WE_out.
- FSM states: IDLE, EXEC, DONE.
  - IDLE & start: latch A, B, op, dest. Single-cycle op goes to DONE; MUL/DIV load counter=ITER-1 and go to EXEC.
  - EXEC: one shift-add / restore-subtract step per cycle. When counter==0, go to DONE; else decrement.
  - DONE: done=1 and WE_out=1 (except on error) for exactly one cycle, then IDLE.
- Latency from the start cycle t: single-cycle ops done at t+1; MUL/DIV done at t+ITER+1 (t+17).
- result, result_hi and flags are registered and held until the next done; they change only on a done cycle. W_out is held the same way.
- start while busy=1 (including the DONE cycle) is ignored, with no side effects. Max issue rate: one op per 2 cycles (single-cycle), one per 18 cycles (MUL/DIV).
- Opcodes (unsigned unless noted):
  - 0 ADD: C=carry out, V=signed ovf.
  - 1 SUB A-B: C=borrow (A<B), V=signed ovf.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL by B[3:0]; 7 SHR logical; 8 SRA.
  - 9 MUL: 32-bit product, {result_hi,result}, C=(result_hi!=0).
  - 10 DIV: result=A/B, result_hi=A%B.
  - 11-15: illegal.
- C=V=0 for every op except those listed above.
- Divide-by-zero: still takes 17 cycles; result=0xFFFF, result_hi=A, flag_err=1, WE_out=0.
- Illegal opcode: done at t+1, result=0, result_hi=0, flag_err=1, WE_out=0, flag_z=1.
- flag_z is computed from result only, never from result_hi.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: opcode 10 is the iterative divider, as specified above.
- Undefined: no divider hardware; opcode 10 is handled as illegal (done at t+1, flag_err=1, WE_out=0).
- MUL is unaffected either way.

Test Plan:
- ADD A=0x7FFF B=0x0001 dest=3 at t -> at t+1: done=1, result=0x8000, V=1, C=0, Z=0, WE_out=1, W_out=3.
- SUB A=0x0003 B=0x0005 -> at t+1: result=0xFFFE, C=1, V=0; then SUB A=B=0x1234 -> result=0, Z=1.
- MUL A=0x1234 B=0x0100 -> busy high t+1..t+17, done at t+17: result=0x3400, result_hi=0x0012, C=1.
- DIV 100/7 -> done at t+17: result=14, result_hi=2. DIV 0x0050/0 -> result=0xFFFF, result_hi=0x0050, err=1, WE_out=0. Without ALU_DIV_EN: DIV gives done at t+1 with err=1.
- Start a MUL, pulse start with ADD at t+5 -> ADD ignored; MUL result unchanged at t+17; busy=0 at t+18, and a new ADD issued at t+18 completes at t+19.
- Start MUL, assert RST_N=0 at t+8 for 1 cycle -> all outputs 0 immediately, no done/WE_out pulse; after release, opcode 12 -> done at t'+1 with err=1, result=0, Z=1.
